// File: rtl/m4_usb_fifo_regs.sv
// ---------------------------------------------------------------------------
// m4_usb_fifo_regs
//
// M4-side end of the USB-serial FIFO pair. A Wishbone slave that gives the M4
// byte-wide access to both FIFOs:
//   - it pops the u2m FIFO (USB -> M4, filled by the USB bridge endpoint);
//   - it pushes the m2u FIFO (M4 -> USB, drained by that endpoint).
// It also provides a status word, sticky error flags, byte counters and an
// RX-available / RX-idle-timeout interrupt.
//
// Register map (word address):
//   0 DATA    R: pop one byte from u2m (0 and RX_UNF if empty)
//             W: push WR_DAT[7:0] into m2u (dropped and TX_OVF if full)
//   1 STATUS  R: [0] u2m_empty [1] m2u_full [7:4] popflag [11:8] pushflag
//                [16] RX_UNF [17] TX_OVF [18] RX_TMO_FLAG
//             W: write-1-to-clear [18:16], gated by BYTE_STB[2]
//   2 IRQ_EN  R/W [1:0]: [0] rx-available, [1] rx-timeout (BYTE_STB[0])
//   3 RX_TMO  R/W [TMO_W-1:0]: idle timeout in cycles, 0 disables it
//   4 COUNT   R: {tx_cnt, rx_cnt}; any write clears both
//   5-7       read 0, writes ignored, still acknowledged
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   WBs_*                   Wishbone slave (3-bit word address, 32-bit data)
//   FIFO_u2m_*              pop side of the USB->M4 FIFO (first-word-fall-through)
//   FIFO_m2u_*              push side of the M4->USB FIFO
//   usb_rx_irq              registered level interrupt to the M4
//
// Bus handshake: an access starts on any cycle with CYC & STB & !ACK. ACK is
// asserted for exactly one cycle on the following cycle, with RD_DAT valid
// alongside it (RD_DAT is 0 whenever ACK is low). The master must drop STB
// or present a new request after ACK; a still-asserted request starts a new
// access the cycle after ACK.
// ---------------------------------------------------------------------------
module m4_usb_fifo_regs #(
  parameter int               TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO_RST = 16'd4800
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  WBs_ADR,
  input  logic        WBs_CYC,
  input  logic        WBs_STB,
  input  logic        WBs_WE,
  input  logic [3:0]  WBs_BYTE_STB,
  input  logic [31:0] WBs_WR_DAT,
  output logic [31:0] WBs_RD_DAT,
  output logic        WBs_ACK,
  output logic        FIFO_u2m_pop,
  input  logic [7:0]  FIFO_u2m_dout,
  input  logic        FIFO_u2m_empty,
  input  logic [3:0]  FIFO_u2m_popflag,
  output logic        FIFO_m2u_push,
  output logic [7:0]  FIFO_m2u_din,
  input  logic        FIFO_m2u_full,
  input  logic [3:0]  FIFO_m2u_pushflag,
  output logic        usb_rx_irq
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_IRQ_EN = 3'd2;
  localparam logic [2:0] A_RX_TMO = 3'd3;
  localparam logic [2:0] A_COUNT  = 3'd4;

  logic             r_ack;
  logic [31:0]      r_rd_dat;
  logic             r_push;
  logic [7:0]       r_din;
  logic             r_irq;
  logic             r_rx_unf;
  logic             r_tx_ovf;
  logic             r_tmo_flag;
  logic [15:0]      r_rx_cnt;
  logic [15:0]      r_tx_cnt;
  logic [1:0]       r_irq_en;
  logic [TMO_W-1:0] r_rx_tmo;
  logic [TMO_W-1:0] r_tmo_cnt;

  logic        w_start;
  logic        w_rd;
  logic        w_wr;
  logic        w_pop;
  logic        w_push_req;
  logic        w_rx_unf_set;
  logic        w_tx_ovf_set;
  logic        w_sts_w1c;
  logic        w_clr_unf;
  logic        w_clr_ovf;
  logic        w_clr_tmo;
  logic        w_tmo_hit;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  // A new access may only start once the previous ACK has been seen.
  assign w_start = WBs_CYC & WBs_STB & ~r_ack;
  assign w_rd    = w_start & ~WBs_WE;
  assign w_wr    = w_start &  WBs_WE;

  // The u2m FIFO is first-word-fall-through: the head byte is captured into
  // RD_DAT on the same edge that pops it. Gated by reset_n so an access that
  // collides with reset never consumes a byte.
  assign w_pop        = w_rd & (WBs_ADR == A_DATA) & ~FIFO_u2m_empty & reset_n;
  assign w_push_req   = w_wr & (WBs_ADR == A_DATA) & ~FIFO_m2u_full;
  assign w_rx_unf_set = w_rd & (WBs_ADR == A_DATA) &  FIFO_u2m_empty;
  assign w_tx_ovf_set = w_wr & (WBs_ADR == A_DATA) &  FIFO_m2u_full;

  assign w_sts_w1c = w_wr & (WBs_ADR == A_STATUS) & WBs_BYTE_STB[2];
  assign w_clr_unf = w_sts_w1c & WBs_WR_DAT[16];
  assign w_clr_ovf = w_sts_w1c & WBs_WR_DAT[17];
  assign w_clr_tmo = w_sts_w1c & WBs_WR_DAT[18];

  // Idle timeout: the counter has seen RX_TMO-1 idle cycles with data waiting
  // and this is the RX_TMO-th. Qualified by !empty so RX_TMO=1 cannot fire on
  // an empty FIFO where the counter is parked at 0.
  assign w_tmo_hit = (r_rx_tmo != '0) & ~FIFO_u2m_empty & ~w_pop &
                     (r_tmo_cnt == (r_rx_tmo - TMO_W'(1)));

  always_comb begin
    w_rd_mux = 32'd0;
    case (WBs_ADR)
      A_DATA:   w_rd_mux = FIFO_u2m_empty ? 32'd0 : {24'd0, FIFO_u2m_dout};
      A_STATUS: w_rd_mux = {13'd0, r_tmo_flag, r_tx_ovf, r_rx_unf,
                            4'd0, FIFO_m2u_pushflag, FIFO_u2m_popflag,
                            2'd0, FIFO_m2u_full, FIFO_u2m_empty};
      A_IRQ_EN: w_rd_mux = {30'd0, r_irq_en};
      A_RX_TMO: w_rd_mux = {{(32-TMO_W){1'b0}}, r_rx_tmo};
      A_COUNT:  w_rd_mux = {r_tx_cnt, r_rx_cnt};
      default:  w_rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ack      <= 1'b0;
      r_rd_dat   <= 32'd0;
      r_push     <= 1'b0;
      r_din      <= 8'd0;
      r_irq      <= 1'b0;
      r_rx_unf   <= 1'b0;
      r_tx_ovf   <= 1'b0;
      r_tmo_flag <= 1'b0;
      r_rx_cnt   <= 16'd0;
      r_tx_cnt   <= 16'd0;
      r_irq_en   <= 2'd0;
      r_rx_tmo   <= TMO_RST;
      r_tmo_cnt  <= '0;
    end else begin
      r_ack    <= w_start;
      r_rd_dat <= w_rd ? w_rd_mux : 32'd0;

      // The push is issued alongside ACK; full was checked at access start
      // and nothing else pushes this FIFO, so it cannot fill in between.
      r_push <= w_push_req;
      if (w_push_req) r_din <= WBs_WR_DAT[7:0];

      // Sticky flags: a set in the same cycle as a clear wins.
      r_rx_unf   <= w_rx_unf_set | (r_rx_unf & ~w_clr_unf);
      r_tx_ovf   <= w_tx_ovf_set | (r_tx_ovf & ~w_clr_ovf);
      r_tmo_flag <= w_tmo_hit | (r_tmo_flag & ~(w_clr_tmo | w_pop));

      if (w_wr && (WBs_ADR == A_COUNT)) begin
        r_rx_cnt <= 16'd0;
        r_tx_cnt <= 16'd0;
      end else begin
        if (w_pop)      r_rx_cnt <= r_rx_cnt + 16'd1;
        if (w_push_req) r_tx_cnt <= r_tx_cnt + 16'd1;
      end

      if (w_wr && (WBs_ADR == A_IRQ_EN) && WBs_BYTE_STB[0])
        r_irq_en <= WBs_WR_DAT[1:0];
      if (w_wr && (WBs_ADR == A_RX_TMO))
        r_rx_tmo <= WBs_WR_DAT[TMO_W-1:0];

      // Holding at the match point keeps the flag asserted while the byte
      // stays unread, so a W1C alone cannot clear it; reading the byte does.
      if (FIFO_u2m_empty || w_pop)
        r_tmo_cnt <= '0;
      else if (w_tmo_hit)
        r_tmo_cnt <= r_tmo_cnt;
      else if (r_tmo_cnt != '1)
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);

      r_irq <= (r_irq_en[0] & ~FIFO_u2m_empty) | (r_irq_en[1] & r_tmo_flag);
    end
  end

  assign WBs_ACK       = r_ack;
  assign WBs_RD_DAT    = r_rd_dat;
  assign FIFO_u2m_pop  = w_pop;
  assign FIFO_m2u_push = r_push;
  assign FIFO_m2u_din  = r_din;
  assign usb_rx_irq    = r_irq;

  // Byte strobes 1 and 3 and the upper write-data bits have no function.
  assign w_unused = ^{WBs_BYTE_STB, WBs_WR_DAT};

endmodule
